multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//   Multi-cycle sequencer for the RV32I datapath. Decodes the IR opcode and
//   steps the datapath through FETCH/DECODE/EXECUTE/MEM/WB, one state per clock.
//   Handshakes with a shared instruction/data memory. Drives every datapath
//   mux select and write enable. Traps on illegal opcodes and memory timeouts.
// PARAMETERS
//   MEM_TIMEOUT  255  max wait cycles for mem_ready in a memory state; 0 disables
// PORTS
//   clk          in   1  single clock, rising edge
//   rst_n        in   1  asynchronous reset, active low
//   opcode       in   7  IR[6:0]; stable from DECODE until next FETCH completes
//   mem_ready    in   1  memory accepts/returns this cycle
//   br_taken     in   1  datapath branch-compare result, valid in BRANCH
//   mem_req      out  1  memory access request
//   mem_we       out  1  1=write (store), 0=read
//   iord         out  1  mem address: 0=PC, 1=ALUOut
//   ir_write     out  1  load IR from memory read data
//   pc_write     out  1  load PC
//   pc_src       out  1  PC source: 0=ALU result (PC+4), 1=ALUOut (branch target)
//   alu_src_a    out  2  00=PC, 01=rs1, 10=oldPC
//   alu_src_b    out  2  00=rs2, 01=const 4, 10=imm
//   alu_op       out  2  00=add, 10=funct-decoded, 11=branch compare
//   reg_write    out  1  register file write enable
//   mem_to_reg   out  1  writeback source: 0=ALUOut, 1=MDR
//   instr_done   out  1  1-cycle pulse on last cycle of each retired instruction
//   illegal_op   out  1  sticky; set on entering TRAP
//   mem_err      out  1  sticky; set on entering ERROR
//   state        out  4  current state (debug)
// BEHAVIOUR
//   - States: INIT=F, FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5,
//     EXEC=6, WB_ALU=7, BRANCH=8, TRAP=9, ERROR=A.
//   - Reset: rst_n low -> state=INIT, timeout counter=0; all outputs 0.
//     INIT drives all outputs 0 and goes to FETCH next cycle.
//   - Reset mid-operation: same as power-up; no partial writes after rst_n falls.
//   - Outputs are Moore-decoded from state. Exceptions, which also depend on
//     inputs: pc_write/ir_write in FETCH, pc_write in BRANCH, instr_done.
//   - FETCH: mem_req=1, iord=0, src_a=00, src_b=01, alu_op=00.
//     Holds until mem_ready=1; on that cycle ir_write=1, pc_write=1, pc_src=0,
//     and next state is DECODE.
//   - DECODE: src_a=10, src_b=10, alu_op=00 (precomputes branch target).
//     Next state by opcode:
//       0110011 / 0010011 -> EXEC
//       0000011 / 0100011 -> MEM_ADDR
//       1100011 -> BRANCH
//       other -> TRAP
//   - EXEC: src_a=01, alu_op=10; src_b=00 for 0110011, 10 for 0010011. Next WB_ALU.
//   - WB_ALU: reg_write=1, mem_to_reg=0, instr_done=1. Next FETCH.
//   - MEM_ADDR: src_a=01, src_b=10, alu_op=00. Next MEM_RD (load) or MEM_WR (store).
//   - MEM_RD: mem_req=1, iord=1, mem_we=0. Holds until mem_ready; then MEM_WB.
//   - MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1. Next FETCH.
//   - MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready: instr_done=1, next FETCH.
//   - BRANCH: src_a=01, src_b=00, alu_op=11, pc_src=1, pc_write=br_taken,
//     instr_done=1. Next FETCH.
//   - Latency with zero-wait memory (mem_ready=1 on first request cycle):
//     R/I-ALU=4, load=5, store=4, branch=3 cycles. Each wait cycle adds 1.
//   - mem_req stays high and iord/mem_we stay stable throughout a wait.
//   - Timeout counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each
//     cycle mem_ready=0. When count reaches MEM_TIMEOUT (and MEM_TIMEOUT!=0),
//     next state is ERROR. If mem_ready=1 in that same cycle, mem_ready wins.
//   - TRAP / ERROR are terminal until reset; all outputs 0 except the
//     respective sticky flag.
// TESTING
//   - Reset release, opcode=0110011, mem_ready=1 -> states F,0,1,6,7,0;
//     reg_write=1 only in state 7; instr_done pulse at cycle 4.
//   - Load 0000011, mem_ready=1 -> 0,1,2,3,4; iord=1 in state 3;
//     mem_to_reg=1 and reg_write=1 in state 4.
//   - Store 0100011, mem_ready low 3 cycles in MEM_WR -> mem_req/mem_we high
//     4 cycles, then FETCH; reg_write never 1.
//   - Branch 1100011 with br_taken=1 -> pc_write=1, pc_src=1 in state 8.
//     With br_taken=0 -> pc_write=0.
//   - opcode=1111111 -> TRAP; illegal_op=1 held; mem_req=0 until rst_n low.
//   - MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERROR after 4 cycles,
//     mem_err=1; rst_n pulse mid-wait -> INIT, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer.
// Walks the shared-memory datapath through FETCH/DECODE/EXECUTE/MEM/WB one
// state per clock, decoding every mux select and write enable from the
// current state. Illegal opcodes park in TRAP and memory stalls longer than
// MEM_TIMEOUT cycles park in ERROR; both hold until reset.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  // Counter only has to hold values up to MEM_TIMEOUT.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEM_ADDR = 4'h2,
    S_MEM_RD   = 4'h3,
    S_MEM_WB   = 4'h4,
    S_MEM_WR   = 4'h5,
    S_EXEC     = 4'h6,
    S_WB_ALU   = 4'h7,
    S_BRANCH   = 4'h8,
    S_TRAP     = 4'h9,
    S_ERROR    = 4'hA,
    S_INIT     = 4'hF
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_mem_state;
  logic            w_timeout;

  assign state = r_state;

  // States in which the FSM is waiting on the memory handshake.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);

  // Wait budget exhausted; a ready in this same cycle still takes priority.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_cnt == CW'(MEM_TIMEOUT));

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Wait counter restarts on every state change, so entry into any memory
  // state sees zero; it only advances while memory is stalling.
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if (w_mem_state && !mem_ready && (MEM_TIMEOUT != 0)) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Next-state selection and Moore output decode (with the few input-gated strobes).
  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    mem_err      = 1'b0;

    case (r_state)
      S_INIT: begin
        w_state_next = S_FETCH;
      end

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_ERROR;
        end
      end

      S_DECODE: begin
        // ALU precomputes oldPC + imm so BRANCH can use ALUOut as the target.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_R, OP_I:        w_state_next = S_EXEC;
          OP_LOAD, OP_STORE: w_state_next = S_MEM_ADDR;
          OP_BR:             w_state_next = S_BRANCH;
          default:           w_state_next = S_TRAP;
        endcase
      end

      S_EXEC: begin
        alu_src_a    = 2'b01;
        alu_op       = 2'b10;
        alu_src_b    = (opcode == OP_I) ? 2'b10 : 2'b00;
        w_state_next = S_WB_ALU;
      end

      S_WB_ALU: begin
        reg_write    = 1'b1;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        w_state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          w_state_next = S_MEM_WB;
        end else if (w_timeout) begin
          w_state_next = S_ERROR;
        end
      end

      S_MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          instr_done   = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_state_next = S_ERROR;
        end
      end

      S_BRANCH: begin
        alu_src_a    = 2'b01;
        alu_op       = 2'b11;
        pc_src       = 1'b1;
        pc_write     = br_taken;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end

      S_TRAP: begin
        illegal_op = 1'b1;
      end

      S_ERROR: begin
        mem_err = 1'b1;
      end

      default: begin
        // Unused encodings recover through INIT.
        w_state_next = S_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm (built with MEM_TIMEOUT=4).
// Each cycle the expected state/output vector is pushed when inputs are
// driven and popped and compared on the following falling edge.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       br_taken;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, instr_done, illegal_op, mem_err;
  logic [3:0] state;
  logic [20:0] w_obs;

  int checks = 0;
  int errors = 0;
  logic [20:0] sb[$];

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_err(mem_err), .state(state)
  );

  assign w_obs = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
                  instr_done, illegal_op, mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for a state, written from the control-signal table.
  function automatic logic [16:0] exp_o(input logic [3:0] st, input logic [6:0] opc,
                                        input logic rdy, input logic br);
    logic req, we, io, irw, pcw, pcs, rw, m2r, dn, ill, me;
    logic [1:0] a, b, op;
    req = 0; we = 0; io = 0; irw = 0; pcw = 0; pcs = 0;
    rw = 0; m2r = 0; dn = 0; ill = 0; me = 0; a = 0; b = 0; op = 0;
    case (st)
      4'h0: begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      4'h1: begin a = 2'b10; b = 2'b10; end
      4'h2: begin a = 2'b01; b = 2'b10; end
      4'h3: begin req = 1; io = 1; end
      4'h4: begin rw = 1; m2r = 1; dn = 1; end
      4'h5: begin req = 1; io = 1; we = 1; dn = rdy; end
      4'h6: begin a = 2'b01; op = 2'b10; b = (opc == OP_I) ? 2'b10 : 2'b00; end
      4'h7: begin rw = 1; dn = 1; end
      4'h8: begin a = 2'b01; op = 2'b11; pcs = 1; pcw = br; dn = 1; end
      4'h9: ill = 1;
      4'hA: me = 1;
      default: ;
    endcase
    return {req, we, io, irw, pcw, pcs, a, b, op, rw, m2r, dn, ill, me};
  endfunction

  // One clock of stimulus; the expectation goes into the scoreboard.
  task automatic drive(input logic [6:0] opc, input logic rdy, input logic br,
                       input logic [3:0] es);
    @(posedge clk); #1;
    opcode = opc; mem_ready = rdy; br_taken = br;
    sb.push_back({es, exp_o(es, opc, rdy, br)});
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; opcode = 7'd0; mem_ready = 1'b0; br_taken = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] got, exp;
    opcode = OP_R; mem_ready = 1'b1; br_taken = 1'b1;
    rst_n = 1'b1; #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sb.push_back({4'hF, exp_o(4'hF, OP_R, 1'b1, 1'b1)});
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("reset cyc %0d st=%h", i, got[20:17]);
    end
    rst_n = 1'b1;
  endtask

  // Starts each scenario from INIT and checks the INIT cycle.
  task automatic test_init_cycle(input string nm);
    logic [20:0] got, exp;
    apply_reset();
    sb.push_back({4'hF, exp_o(4'hF, 7'd0, 1'b0, 1'b0)});
    got = w_obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s init: state=%h outs=%b want state=%h outs=%b", nm, got[20:17], got[16:0], exp[20:17], exp[16:0]);
    end else $display("%s init st=%h", nm, got[20:17]);
  endtask

  task automatic test_rtype();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    es = '{4'h0, 4'h1, 4'h6, 4'h7, 4'h0};
    test_init_cycle("rtype");
    for (int i = 0; i < es.size(); i++) begin
      drive(OP_R, 1'b1, 1'b0, es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rtype cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("rtype cyc %0d st=%h", i, got[20:17]);
    end
  endtask

  task automatic test_load();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    es = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
    test_init_cycle("load");
    for (int i = 0; i < es.size(); i++) begin
      drive(OP_LD, 1'b1, 1'b0, es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL load cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("load cyc %0d st=%h", i, got[20:17]);
    end
  endtask

  task automatic test_store_wait();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    bit rq[$];
    es = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0};
    rq = '{1, 1, 1, 0, 0, 0, 1, 1};
    test_init_cycle("store");
    for (int i = 0; i < es.size(); i++) begin
      drive(OP_ST, rq[i], 1'b0, es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL store cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("store cyc %0d st=%h", i, got[20:17]);
    end
  endtask

  task automatic test_branch();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    bit bt[$];
    es = '{4'h0, 4'h1, 4'h8, 4'h0, 4'h1, 4'h8, 4'h0};
    bt = '{0, 0, 1, 0, 0, 0, 0};
    test_init_cycle("branch");
    for (int i = 0; i < es.size(); i++) begin
      drive(OP_BR, 1'b1, bt[i], es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL branch cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("branch cyc %0d st=%h br=%0d", i, got[20:17], bt[i]);
    end
  endtask

  // I-type, stalled load, then R-type with no reset in between.
  task automatic test_back_to_back();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    logic [6:0] op[$];
    bit rq[$];
    es = '{4'h0, 4'h1, 4'h6, 4'h7, 4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4,
           4'h0, 4'h1, 4'h6, 4'h7, 4'h0};
    op = '{OP_I, OP_I, OP_I, OP_I, OP_LD, OP_LD, OP_LD, OP_LD, OP_LD, OP_LD, OP_LD,
           OP_R, OP_R, OP_R, OP_R, OP_R};
    rq = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    test_init_cycle("b2b");
    for (int i = 0; i < es.size(); i++) begin
      drive(op[i], rq[i], 1'b0, es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("b2b cyc %0d st=%h", i, got[20:17]);
    end
  endtask

  task automatic test_trap();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    es = '{4'h0, 4'h1, 4'h9, 4'h9, 4'h9, 4'h9};
    test_init_cycle("trap");
    for (int i = 0; i < es.size(); i++) begin
      drive(OP_BAD, 1'b1, 1'b1, es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL trap cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("trap cyc %0d st=%h", i, got[20:17]);
    end
  endtask

  // Ready never comes: four wait cycles, a fifth at the limit, then ERROR.
  task automatic test_timeout();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    es = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'hA};
    test_init_cycle("timeout");
    for (int i = 0; i < es.size(); i++) begin
      drive(OP_R, 1'b0, 1'b0, es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL timeout cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("timeout cyc %0d st=%h", i, got[20:17]);
    end
  endtask

  // Ready arriving on the limit cycle still completes the fetch.
  task automatic test_timeout_edge();
    logic [20:0] got, exp;
    logic [3:0] es[$];
    bit rq[$];
    es = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h6, 4'h7};
    rq = '{0, 0, 0, 0, 1, 1, 1, 1};
    test_init_cycle("tmo_edge");
    for (int i = 0; i < es.size(); i++) begin
      drive(OP_R, rq[i], 1'b0, es[i]);
      got = w_obs; exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL tmo_edge cyc %0d: state=%h outs=%b want state=%h outs=%b", i, got[20:17], got[16:0], exp[20:17], exp[16:0]);
      end else $display("tmo_edge cyc %0d st=%h", i, got[20:17]);
    end
  endtask

  // Reset asserted in the middle of a fetch wait, with ready high.
  task automatic test_reset_mid();
    logic [20:0] got, exp;
    test_init_cycle("rst_mid");
    drive(OP_R, 1'b0, 1'b0, 4'h0);
    got = w_obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rst_mid wait: state=%h outs=%b want state=%h outs=%b", got[20:17], got[16:0], exp[20:17], exp[16:0]);
    end else $display("rst_mid wait st=%h", got[20:17]);
    @(posedge clk); #1;
    mem_ready = 1'b1; rst_n = 1'b0;
    sb.push_back({4'hF, exp_o(4'hF, OP_R, 1'b1, 1'b0)});
    @(negedge clk);
    got = w_obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rst_mid held: state=%h outs=%b want state=%h outs=%b", got[20:17], got[16:0], exp[20:17], exp[16:0]);
    end else $display("rst_mid held st=%h", got[20:17]);
    rst_n = 1'b1;
    drive(OP_R, 1'b0, 1'b0, 4'h0);
    got = w_obs; exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rst_mid refetch: state=%h outs=%b want state=%h outs=%b", got[20:17], got[16:0], exp[20:17], exp[16:0]);
    end else $display("rst_mid refetch st=%h", got[20:17]);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store_wait();
    test_branch();
    test_back_to_back();
    test_trap();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
